// File: rtl/seq_div_if.sv
// Operand/result handshake bundle for the iterative divider.
// The master drives operands and result acceptance; the divider is the slave.
interface seq_div_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB first,
// fixed WIDTH-cycle latency, valid/ready on operands and results.
module seq_div #(
    parameter int unsigned WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    seq_div_if.slave bus
);
    localparam int unsigned     CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] r_sub;
    logic             ge;

    assign accept    = bus.in_valid && in_ready;
    assign last_step = (cnt_q == LAST);

    // The WIDTH+1-bit partial remainder is formed here from the stored WIDTH-bit
    // value; after each step it is always < divisor, so the top bit never needs storing.
    assign r_shift = {rem_q, dvd_q[WIDTH-1]};
    assign ge      = (r_shift >= {1'b0, dvs_q});
    assign r_sub   = r_shift[WIDTH-1:0] - dvs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)        state_d = BUSY;
            BUSY:    if (last_step)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
    end

    always_comb begin
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        rem_d = rem_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        dbz_d = dbz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dvd_d = bus.a;
                    dvs_d = bus.b;
                    dbz_d = (bus.b == '0);
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = '0;
                end
            end
            BUSY: begin
                rem_d = ge ? r_sub : r_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ge};
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            dbz_q <= dbz_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed scenarios plus a randomized
// back-to-back run scored against a plain-arithmetic reference.
module tb_seq_div;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_div_if #(.WIDTH(W)) bus ();
    seq_div #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned errors = 0;
    int unsigned checks = 0;

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    // Issue one operation; lat = edges from acceptance to the edge before out_valid is seen.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold_ready,
                         output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int busy_rdy);
        int guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = hold_ready;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        lat = 0; busy_rdy = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) busy_rdy++;
            @(negedge clk);
            lat++;
        end
        if (bus.in_ready) busy_rdy++;
        q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.quotient !== '0 ||
            bus.remainder !== '0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b q=%h r=%h dbz=%b expected 0 0 0000 0000 0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        int lat, br; logic [W-1:0] q, r; logic z;
        do_op(16'd100, 16'd7, 1'b0, lat, q, r, z, br);
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL basic_latency: got %0d expected 16", lat); end
        checks++;
        if (q !== 16'd14 || r !== 16'd2 || z !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b expected 14 2 0", q, r, z);
        end
        checks++;
        if (br !== 0) begin errors++; $display("FAIL basic_in_ready_busy: high %0d cycles expected 0", br); end
    endtask

    task automatic test_extremes();
        logic [W-1:0] tbl [3][4] = '{'{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000},
                                     '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000},
                                     '{16'h0005, 16'h0009, 16'h0000, 16'h0005}};
        int lat, br; logic [W-1:0] q, r; logic z;
        for (int i = 0; i < 3; i++) begin
            do_op(tbl[i][0], tbl[i][1], 1'b1, lat, q, r, z, br);
            checks++;
            if (q !== tbl[i][2] || r !== tbl[i][3] || z !== 1'b0 || lat !== 16) begin
                errors++;
                $display("FAIL extreme_%0d: q=%h r=%h dbz=%b lat=%0d expected %h %h 0 16",
                         i, q, r, z, lat, tbl[i][2], tbl[i][3]);
            end
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL extreme_%0d_idle: in_ready=%b out_valid=%b expected 1 0",
                         i, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, br; logic [W-1:0] q, r; logic z;
        do_op(16'd1234, 16'd0, 1'b0, lat, q, r, z, br);
        checks++;
        if (q !== 16'hFFFF || r !== 16'd1234 || z !== 1'b1 || lat !== 16) begin
            errors++;
            $display("FAIL div_by_zero: q=%h r=%0d dbz=%b lat=%0d expected ffff 1234 1 16", q, r, z, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] eq, er, nq, nr; logic ez, nz;
        int lat, bad;
        ref_div(16'd40000, 16'd123, eq, er, ez);
        ref_div(16'd555, 16'd11, nq, nr, nz);
        @(negedge clk);
        bus.a = 16'd40000; bus.b = 16'd123; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
        bus.a = 16'd555; bus.b = 16'd11; bus.in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== eq ||
                bus.remainder !== er || bus.div_by_zero !== ez) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0 || lat !== 16) begin
            errors++;
            $display("FAIL backpressure_hold: %0d unstable cycles lat=%0d expected 0 and 16 (q=%0d r=%0d)",
                     bad, lat, eq, er);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_drain: in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (bus.quotient !== nq || bus.remainder !== nr || bus.div_by_zero !== nz || lat !== 16) begin
            errors++;
            $display("FAIL backpressure_next: q=%0d r=%0d dbz=%b lat=%0d expected %0d %0d %b 16",
                     bus.quotient, bus.remainder, bus.div_by_zero, lat, nq, nr, nz);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int lat, br; logic [W-1:0] q, r; logic z;
        @(negedge clk);
        bus.a = 16'd1000; bus.b = 16'd3; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_in_rst: got %b expected 0", bus.in_ready); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.quotient !== '0) begin
            errors++;
            $display("FAIL midrst_after_edge: out_valid=%b in_ready=%b q=%h expected 0 0 0000",
                     bus.out_valid, bus.in_ready, bus.quotient);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release: in_ready=%b expected 1", bus.in_ready); end
        do_op(16'd1000, 16'd3, 1'b0, lat, q, r, z, br);
        checks++;
        if (q !== 16'd333 || r !== 16'd1 || z !== 1'b0 || lat !== 16) begin
            errors++;
            $display("FAIL midrst_redo: q=%0d r=%0d dbz=%b lat=%0d expected 333 1 0 16", q, r, z, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q [$];
        logic [W-1:0] exp_r [$];
        logic         exp_z [$];
        int got = 0;
        int sent = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [W-1:0] a, b, q, r; logic z;
                    int guard = 0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    a = W'($urandom);
                    case ($urandom_range(0, 5))
                        0: b = '0;
                        1: b = 16'd1;
                        2: b = W'($urandom_range(2, 15));
                        3: b = a;
                        4: b = W'(a + 1);
                        default: b = W'($urandom);
                    endcase
                    bus.a = a; bus.b = b; bus.in_valid = 1'b1;
                    while (!bus.in_ready && guard < 1000) begin @(negedge clk); guard++; end
                    if (guard >= 1000) break;
                    ref_div(a, b, q, r, z);
                    exp_q.push_back(q); exp_r.push_back(r); exp_z.push_back(z);
                    sent++;
                    @(posedge clk);
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                end
            end
            begin
                int cyc = 0;
                while (got < 200 && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    bus.out_ready = 1'($urandom_range(0, 1));
                    if (bus.out_valid && bus.out_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL b2b_extra_result: q=%h with no accepted operation pending", bus.quotient);
                        end else begin
                            logic [W-1:0] q, r; logic z;
                            q = exp_q.pop_front(); r = exp_r.pop_front(); z = exp_z.pop_front();
                            if (bus.quotient !== q || bus.remainder !== r || bus.div_by_zero !== z) begin
                                errors++;
                                $display("FAIL b2b_result_%0d: q=%h r=%h dbz=%b expected %h %h %b",
                                         got, bus.quotient, bus.remainder, bus.div_by_zero, q, r, z);
                            end
                        end
                        got++;
                    end
                end
                bus.out_ready = 1'b0;
            end
        join
        checks++;
        if (got !== 200 || sent !== 200 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_count: sent=%0d got=%0d pending=%0d expected 200 200 0", sent, got, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_extremes();
        test_div_by_zero();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
